// File: rtl/l2_burst_adaptor_if.sv
// -----------------------------------------------------------------------------
// l2_burst_adaptor_if
// Bundles the L2-controller side (whole-line requests) and the physical memory
// side (multi-beat bursts) of the L2 burst adaptor into one interface.
//
// Parameters:
//   s_offset : log2 bytes per line (line width s_line = 8*2**s_offset bits)
//   s_burst  : memory beat width in bits
//
// Signals (named from the adaptor's point of view):
//   line_i    line to write back          line_o    assembled read line
//   address_i line address from L2        resp_o    one-cycle completion pulse
//   read_i    line read request (level)   write_i   line write request (level)
//   burst_i   read beat from memory       burst_o   write beat to memory
//   address_o burst address (line aligned)
//   read_o    memory burst read request   write_o   memory burst write request
//   resp_i    memory beat handshake
//
// Modports:
//   slave  : the adaptor itself
//   master : the L2 controller / memory model driving the adaptor
// -----------------------------------------------------------------------------
interface l2_burst_adaptor_if #(
   parameter int s_offset = 5,
   parameter int s_burst  = 64
);
   localparam int s_line = 8 * (2 ** s_offset);

   logic [s_line-1:0]  line_i;
   logic [s_line-1:0]  line_o;
   logic [31:0]        address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   logic [s_burst-1:0] burst_i;
   logic [s_burst-1:0] burst_o;
   logic [31:0]        address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/l2_burst_adaptor.sv
// -----------------------------------------------------------------------------
// l2_burst_adaptor
// Memory-side partner of the L2 data arrays. Converts whole-line read/write
// requests from the L2 controller into fixed-length bursts of s_line/s_burst
// beats on the memory port. Reads assemble beats (beat 0 = lowest bits) into
// line_o; writes serialise the line captured at accept onto burst_o.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : l2_burst_adaptor_if.slave (controller and memory signals)
//   perf_reads_o / perf_writes_o / perf_wait_o (32 bit, saturating) exist only
//   when the macro L2_BURST_ADAPTOR_PERF_EN is defined.
//
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module l2_burst_adaptor #(
   parameter int s_offset = 5,
   parameter int s_burst  = 64
) (
   input  logic               clk,
   input  logic               rst,
   l2_burst_adaptor_if.slave  bus
`ifdef L2_BURST_ADAPTOR_PERF_EN
   ,
   output logic [31:0]        perf_reads_o,
   output logic [31:0]        perf_writes_o,
   output logic [31:0]        perf_wait_o
`endif
);

   localparam int s_line = 8 * (2 ** s_offset);
   localparam int beats  = s_line / s_burst;
   localparam int cnt_w  = (beats > 1) ? $clog2(beats) : 1;

   localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);
   // Clears the byte-offset bits so address_o is always line aligned.
   localparam logic [31:0]      addr_mask = ~((32'd1 << s_offset) - 32'd1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [cnt_w-1:0]   cnt_r,   cnt_s;
   logic [s_line-1:0]  buf_r,   buf_s;
   logic [s_line-1:0]  line_r,  line_s;
   logic [31:0]        addr_r,  addr_s;
   logic [s_burst-1:0] burst_r, burst_s;
   logic               read_r,  read_s;
   logic               write_r, write_s;
   logic               resp_r,  resp_s;

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      buf_s   = buf_r;
      line_s  = line_r;
      addr_s  = addr_r;
      burst_s = burst_r;
      read_s  = read_r;
      write_s = write_r;
      resp_s  = 1'b0;

      case (state_r)
         IDLE: begin
            // Write has priority when both requests are raised together.
            if (bus.write_i) begin
               buf_s   = bus.line_i;
               addr_s  = bus.address_i & addr_mask;
               cnt_s   = '0;
               write_s = 1'b1;
               // Beat 0 must already be on burst_o in the first WR cycle.
               burst_s = bus.line_i[s_burst-1:0];
               state_s = WR;
            end else if (bus.read_i) begin
               addr_s  = bus.address_i & addr_mask;
               cnt_s   = '0;
               read_s  = 1'b1;
               state_s = RD;
            end else begin
               state_s = IDLE;
            end
         end

         RD: begin
            if (bus.resp_i) begin
               buf_s[s_burst*int'(cnt_r) +: s_burst] = bus.burst_i;
               if (cnt_r == last_beat) begin
                  // Publish the completed line including the final beat.
                  line_s  = buf_s;
                  read_s  = 1'b0;
                  resp_s  = 1'b1;
                  state_s = DONE;
               end else begin
                  cnt_s = cnt_r + cnt_w'(1);
               end
            end else begin
               state_s = RD;
            end
         end

         WR: begin
            if (bus.resp_i) begin
               if (cnt_r == last_beat) begin
                  write_s = 1'b0;
                  resp_s  = 1'b1;
                  state_s = DONE;
               end else begin
                  cnt_s   = cnt_r + cnt_w'(1);
                  burst_s = buf_r[s_burst*int'(cnt_s) +: s_burst];
               end
            end else begin
               state_s = WR;
            end
         end

         DONE: begin
            // resp_o is high for this cycle only; resp_s defaults low.
            state_s = IDLE;
         end

         default: begin
            state_s = IDLE;
            read_s  = 1'b0;
            write_s = 1'b0;
         end
      endcase
   end

   // State register and all registered outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         buf_r   <= '0;
         line_r  <= '0;
         addr_r  <= 32'd0;
         burst_r <= '0;
         read_r  <= 1'b0;
         write_r <= 1'b0;
         resp_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         buf_r   <= buf_s;
         line_r  <= line_s;
         addr_r  <= addr_s;
         burst_r <= burst_s;
         read_r  <= read_s;
         write_r <= write_s;
         resp_r  <= resp_s;
      end
   end

   assign bus.line_o    = line_r;
   assign bus.address_o = addr_r;
   assign bus.burst_o   = burst_r;
   assign bus.read_o    = read_r;
   assign bus.write_o   = write_r;
   assign bus.resp_o    = resp_r;

`ifdef L2_BURST_ADAPTOR_PERF_EN
   logic        op_wr_r;
   logic [31:0] perf_reads_r;
   logic [31:0] perf_writes_r;
   logic [31:0] perf_wait_r;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction

   // Remember the kind of transaction accepted from IDLE, for DONE accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_wr_r <= 1'b0;
      end else if (state_r == IDLE) begin
         op_wr_r <= bus.write_i;
      end else begin
         op_wr_r <= op_wr_r;
      end
   end

   // Saturating transaction and memory-stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_reads_r  <= 32'd0;
         perf_writes_r <= 32'd0;
         perf_wait_r   <= 32'd0;
      end else begin
         if (state_r == DONE && !op_wr_r) begin
            perf_reads_r <= sat_inc(perf_reads_r);
         end
         if (state_r == DONE && op_wr_r) begin
            perf_writes_r <= sat_inc(perf_writes_r);
         end
         if ((read_r | write_r) & ~bus.resp_i) begin
            perf_wait_r <= sat_inc(perf_wait_r);
         end
      end
   end

   assign perf_reads_o  = perf_reads_r;
   assign perf_writes_o = perf_writes_r;
   assign perf_wait_o   = perf_wait_r;
`endif

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// -----------------------------------------------------------------------------
// tb_l2_burst_adaptor
// Directed self-checking bench for l2_burst_adaptor (s_offset=5, s_burst=64,
// 4 beats per line). Inputs change 1 time unit after a rising edge; outputs
// are checked at the same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_l2_burst_adaptor;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   l2_burst_adaptor_if #(.s_offset(5), .s_burst(64)) bus ();

`ifdef L2_BURST_ADAPTOR_PERF_EN
   logic [31:0] perf_reads;
   logic [31:0] perf_writes;
   logic [31:0] perf_wait;
`endif

   l2_burst_adaptor #(.s_offset(5), .s_burst(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus)
`ifdef L2_BURST_ADAPTOR_PERF_EN
      ,
      .perf_reads_o  (perf_reads),
      .perf_writes_o (perf_writes),
      .perf_wait_o   (perf_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Read transaction; pat bit c = resp_i in burst cycle c, beat k = base+k.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [63:0] base, input logic [7:0] pat, input int n);
      logic [255:0] exp_line;
      int k;
      exp_line = 256'd0;
      k = 0;
      bus.address_i = addr;
      bus.read_i    = 1'b1;
      chk("rd_pre_read_o", bus.read_o, 1'b0);
      tick();
      chk("rd_address_o", bus.address_o, exp_addr);
      bus.address_i = 32'hFFFF_FFFF;
      for (int c = 0; c < n; c++) begin
         chk("rd_read_o_high", bus.read_o, 1'b1);
         chk("rd_resp_o_low", bus.resp_o, 1'b0);
         chk("rd_write_o_low", bus.write_o, 1'b0);
         if (pat[c]) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = base + 64'(k);
            exp_line[64*k +: 64] = base + 64'(k);
            k++;
         end else begin
            bus.resp_i  = 1'b0;
            bus.burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(c);
         end
         tick();
      end
      bus.resp_i = 1'b0;
      bus.read_i = 1'b0;
      chk("rd_done_read_o", bus.read_o, 1'b0);
      chk("rd_done_resp_o", bus.resp_o, 1'b1);
      chk("rd_line_o", bus.line_o, exp_line);
      chk("rd_done_address_o", bus.address_o, exp_addr);
   endtask

   // Write transaction; burst_o must follow the count of accepted beats.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] line, input logic [7:0] pat, input int n,
                           input logic [255:0] exp_line_o);
      int idx;
      idx = 0;
      bus.address_i = addr;
      bus.line_i    = line;
      bus.write_i   = 1'b1;
      chk("wr_pre_write_o", bus.write_o, 1'b0);
      tick();
      chk("wr_address_o", bus.address_o, exp_addr);
      bus.line_i    = ~line;
      bus.address_i = 32'h0;
      for (int c = 0; c < n; c++) begin
         chk("wr_write_o_high", bus.write_o, 1'b1);
         chk("wr_read_o_low", bus.read_o, 1'b0);
         chk("wr_resp_o_low", bus.resp_o, 1'b0);
         chk("wr_burst_o", bus.burst_o, line[64*idx +: 64]);
         bus.resp_i = pat[c];
         if (pat[c]) idx++;
         tick();
      end
      bus.resp_i  = 1'b0;
      bus.write_i = 1'b0;
      chk("wr_done_write_o", bus.write_o, 1'b0);
      chk("wr_done_resp_o", bus.resp_o, 1'b1);
      chk("wr_done_read_o", bus.read_o, 1'b0);
      chk("wr_line_o_kept", bus.line_o, exp_line_o);
   endtask

   // Two idle cycles with a stray resp_i that must be ignored.
   task automatic idle_chk(input logic [255:0] exp_line_o);
      bus.resp_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("idle_resp_o", bus.resp_o, 1'b0);
         chk("idle_read_o", bus.read_o, 1'b0);
         chk("idle_write_o", bus.write_o, 1'b0);
         chk("idle_line_o", bus.line_o, exp_line_o);
      end
      bus.resp_i = 1'b0;
   endtask

   initial begin
      logic [255:0] line_a;
      logic [255:0] line_b;
      logic [255:0] line_d;
      logic [255:0] line_e;
      logic [255:0] line_f;
      n_assert = 0;
      n_fail   = 0;
      line_a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      line_b = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
      line_d = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      line_e = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
      line_f = {64'hF3, 64'hF2, 64'hF1, 64'hF0};

      rst           = 1'b1;
      bus.line_i    = 256'd0;
      bus.address_i = 32'd0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.burst_i   = 64'd0;
      bus.resp_i    = 1'b0;
      tick();
      tick();
      chk("rst_read_o", bus.read_o, 1'b0);
      chk("rst_write_o", bus.write_o, 1'b0);
      chk("rst_resp_o", bus.resp_o, 1'b0);
      chk("rst_address_o", bus.address_o, 32'd0);
      chk("rst_burst_o", bus.burst_o, 64'd0);
      chk("rst_line_o", bus.line_o, 256'd0);
      rst = 1'b0;
      tick();

      // Read, zero wait states.
      do_read(32'h0000_1234, 32'h0000_1220, 64'hA0, 8'b0000_1111, 4);
      chk("t1_line_literal", bus.line_o, line_a);
      idle_chk(line_a);

      // Write with waits: resp_i 1,0,0,1,1,1 -> burst_o D0,D1,D1,D1,D2,D3.
      do_write(32'h0000_ABCD, 32'h0000_ABC0, line_d, 8'b0011_1001, 6, line_a);
      idle_chk(line_a);

      // Read with one wait cycle; garbage on burst_i while resp_i is low.
      do_read(32'h8000_0047, 32'h8000_0040, 64'hB0, 8'b0001_1101, 5);
      chk("t3_line_literal", bus.line_o, line_b);
      idle_chk(line_b);

`ifdef L2_BURST_ADAPTOR_PERF_EN
      chk("perf_reads", perf_reads, 32'd2);
      chk("perf_writes", perf_writes, 32'd1);
      chk("perf_wait", perf_wait, 32'd3);
`endif

      // Simultaneous read and write requests: write only.
      bus.read_i = 1'b1;
      do_write(32'h0000_0500, 32'h0000_0500, line_f, 8'b0000_1111, 4, line_b);
      bus.read_i = 1'b0;
      idle_chk(line_b);

      // Reset in the middle of a read after two beats.
      bus.address_i = 32'h0000_0100;
      bus.read_i    = 1'b1;
      tick();
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hC0;
      tick();
      bus.burst_i = 64'hC1;
      tick();
      rst         = 1'b1;
      bus.read_i  = 1'b0;
      bus.resp_i  = 1'b0;
      tick();
      chk("mrst_read_o", bus.read_o, 1'b0);
      chk("mrst_resp_o", bus.resp_o, 1'b0);
      chk("mrst_line_o", bus.line_o, 256'd0);
      chk("mrst_address_o", bus.address_o, 32'd0);
`ifdef L2_BURST_ADAPTOR_PERF_EN
      chk("mrst_perf_reads", perf_reads, 32'd0);
      chk("mrst_perf_writes", perf_writes, 32'd0);
      chk("mrst_perf_wait", perf_wait, 32'd0);
`endif
      rst = 1'b0;
      tick();
      do_read(32'h0000_0200, 32'h0000_0200, 64'hE0, 8'b0000_1111, 4);
      chk("fresh_line_literal", bus.line_o, line_e);
      idle_chk(line_e);

      // Back-to-back: write raised in the cycle right after the read's resp_o.
      do_read(32'h0000_0300, 32'h0000_0300, 64'hF0, 8'b0000_1111, 4);
      tick();
      chk("b2b_resp_o_single", bus.resp_o, 1'b0);
      do_write(32'h0000_0400, 32'h0000_0400, line_d, 8'b0000_1111, 4, line_f);
      idle_chk(line_f);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
